// File: rtl/mp_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// mp_cmd_sequencer_if: command, calculator and result signals of the sequencer.
// err_count exists only when MP_SEQ_ERRCNT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mp_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [15:0] cmd_c;
  logic [15:0] cmd_d;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic [15:0] D;
  logic [7:0]  opcode;
  logic        compute;
  logic [15:0] calc_out;
  logic [15:0] calc_im;
  logic        res_valid;
  logic [15:0] res_data;
  logic [15:0] res_im;
  logic [7:0]  res_opcode;
  logic        busy;
  logic        err;
`ifdef MP_SEQ_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_c, cmd_d, calc_out, calc_im,
    output cmd_ready, A, B, C, D, opcode, compute, res_valid, res_data, res_im,
           res_opcode, busy, err
`ifdef MP_SEQ_ERRCNT_EN
    , output err_count
`endif
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_c, cmd_d, calc_out, calc_im,
    input  cmd_ready, A, B, C, D, opcode, compute, res_valid, res_data, res_im,
           res_opcode, busy, err
`ifdef MP_SEQ_ERRCNT_EN
    , input err_count
`endif
  );
endinterface

`default_nettype wire

// File: rtl/mp_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// mp_cmd_sequencer: command FIFO feeding MP_calculator, compute pulse, timed capture.
// Optional MP_SEQ_ERRCNT_EN adds a saturating err_count output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mp_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int SHORT_WAIT = 8,
  parameter int LONG_WAIT  = 96,
  parameter int MAX_OP     = 9
) (
  input  logic              clk,
  input  logic              reset,
  mp_cmd_sequencer_if.slave sif
);

  localparam int C_AW   = $clog2(DEPTH);
  localparam int C_WMAX = (LONG_WAIT > SHORT_WAIT) ? LONG_WAIT : SHORT_WAIT;
  localparam int C_CW   = $clog2(C_WMAX) + 1;
  localparam logic [C_AW:0]   C_FULL       = (C_AW + 1)'(DEPTH);
  localparam logic [C_CW-1:0] C_SHORT_LOAD = C_CW'(SHORT_WAIT - 1);
  localparam logic [C_CW-1:0] C_LONG_LOAD  = C_CW'(LONG_WAIT - 1);
  localparam logic [7:0]      C_MAX_OP     = 8'(MAX_OP);
  localparam logic [7:0]      C_LONG_OP    = 8'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [C_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]     count_q, count_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [15:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [C_CW-1:0]   wait_q, wait_d;
  logic [15:0]       res_data_q, res_data_d;
  logic [15:0]       res_im_q, res_im_d;
  logic [7:0]        res_opcode_q, res_opcode_d;
  logic              res_valid_q, res_valid_d;
  logic [71:0]       mem_q [DEPTH];
  logic [71:0]       w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_compute;
  logic              w_err;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {sif.cmd_opcode, sif.cmd_a, sif.cmd_b, sif.cmd_c, sif.cmd_d};
    end
  end

  always_comb begin
    w_push       = sif.cmd_valid && cmd_ready_q;
    w_pop        = (state_q == S_IDLE) && (count_q != '0);
    w_head       = mem_q[rd_ptr_q];
    w_compute    = 1'b0;
    w_err        = 1'b0;
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;
    opcode_d     = opcode_q;
    wait_d       = wait_q;
    res_data_d   = res_data_q;
    res_im_d     = res_im_q;
    res_opcode_d = res_opcode_q;
    res_valid_d  = 1'b0;

    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Registered from the next count, so a pop while full frees a slot one cycle later.
    cmd_ready_d = (count_d != C_FULL);

    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          {opcode_d, a_d, b_d, c_d, d_d} = w_head;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (opcode_q > C_MAX_OP) begin
          w_err   = 1'b1;
          state_d = S_IDLE;
        end else begin
          w_compute = 1'b1;
          wait_d    = (opcode_q == C_LONG_OP) ? C_LONG_LOAD : C_SHORT_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Capture on the last wait cycle so res_valid is high during CAPTURE.
        if (wait_q == '0) begin
          res_data_d   = sif.calc_out;
          res_im_d     = sif.calc_im;
          res_opcode_d = opcode_q;
          res_valid_d  = 1'b1;
          state_d      = S_CAPTURE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_ready_q  <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      opcode_q     <= '0;
      wait_q       <= '0;
      res_data_q   <= '0;
      res_im_q     <= '0;
      res_opcode_q <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_ready_q  <= cmd_ready_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
      opcode_q     <= opcode_d;
      wait_q       <= wait_d;
      res_data_q   <= res_data_d;
      res_im_q     <= res_im_d;
      res_opcode_q <= res_opcode_d;
      res_valid_q  <= res_valid_d;
    end
  end

`ifdef MP_SEQ_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (w_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign sif.err_count = err_count_q;
`endif

  assign sif.cmd_ready  = cmd_ready_q;
  assign sif.A          = a_q;
  assign sif.B          = b_q;
  assign sif.C          = c_q;
  assign sif.D          = d_q;
  assign sif.opcode     = opcode_q;
  assign sif.compute    = w_compute;
  assign sif.err        = w_err;
  assign sif.res_valid  = res_valid_q;
  assign sif.res_data   = res_data_q;
  assign sif.res_im     = res_im_q;
  assign sif.res_opcode = res_opcode_q;
  assign sif.busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_mp_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mp_cmd_sequencer: vector table plus result scoreboard for mp_cmd_sequencer.
// A small stand-in calculator model drives calc_out/calc_im from A-D/opcode.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mp_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp_cmd_sequencer_if sif ();

  mp_cmd_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  function automatic logic [31:0] calc_model(input logic [7:0] op,
                                             input logic [15:0] a, b, c, d);
    logic [15:0] o;
    logic [15:0] im;
    o  = '0;
    im = '0;
    case (op)
      8'd0: o = a + b;
      8'd1: o = a - b;
      8'd2: {im, o} = 32'(a) * 32'(b);
      8'd3: if (b != 16'd0) begin o = a / b; im = a % b; end
      8'd4: begin o = a + b + c + d; im = a ^ b ^ c ^ d; end
      8'd7: begin o = a * b + c; im = 16'hA5A5 ^ d; end
      default: begin o = a ^ c; im = b + d; end
    endcase
    return {im, o};
  endfunction

  assign {sif.calc_im, sif.calc_out} = calc_model(sif.opcode, sif.A, sif.B, sif.C, sif.D);

  typedef struct {
    logic [7:0]  op;
    logic [15:0] data;
    logic [15:0] im;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a, b, c, d;
    bit          exp_err;
  } vec_t;

  exp_t        sbq[$];
  exp_t        e_mon;
  int          n_compute = 0;
  int          n_err = 0;
  int          n_res = 0;
  int          comp_cyc = 0;
  int          push_cyc = 0;
  bit          inflight = 1'b0;
  bit          unstable = 1'b0;
  logic [71:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor: operands must hold from compute until capture.
  always @(negedge clk) begin
    if (reset) begin
      inflight = 1'b0;
    end else begin
      if (inflight && ({sif.opcode, sif.A, sif.B, sif.C, sif.D} != held)) unstable = 1'b1;
      if (sif.compute) begin
        n_compute++;
        comp_cyc = cyc;
        held     = {sif.opcode, sif.A, sif.B, sif.C, sif.D};
        inflight = 1'b1;
        unstable = 1'b0;
      end
      if (sif.err) n_err++;
      if (sif.res_valid) begin
        n_res++;
        if (sbq.size() == 0) begin
          check("unexpected_result_opcode", {24'd0, sif.res_opcode}, 32'hFFFF_FFFF);
        end else begin
          e_mon = sbq.pop_front();
          check("res_opcode", {24'd0, sif.res_opcode}, {24'd0, e_mon.op});
          check("res_data", {16'd0, sif.res_data}, {16'd0, e_mon.data});
          check("res_im", {16'd0, sif.res_im}, {16'd0, e_mon.im});
          check("compute_to_res_valid", cyc - comp_cyc, e_mon.lat);
          check("operands_stable", {31'd0, unstable}, 32'd0);
        end
        inflight = 1'b0;
      end
    end
  end

  task automatic sb_push(input logic [7:0] op, input logic [15:0] a, b, c, d);
    exp_t e;
    e.op = op;
    {e.im, e.data} = calc_model(op, a, b, c, d);
    e.lat = (op == 8'd7) ? 97 : 9;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [7:0] op, input logic [15:0] a, b, c, d);
    sif.cmd_valid  = 1'b1;
    sif.cmd_opcode = op;
    sif.cmd_a = a;
    sif.cmd_b = b;
    sif.cmd_c = c;
    sif.cmd_d = d;
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [15:0] a, b, c, d,
                          input bit expect_res);
    int n;
    n = 0;
    @(negedge clk);
    while (!sif.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sif.cmd_ready) check("push_ready_timeout", {31'd0, sif.cmd_ready}, 32'd1);
    drive(op, a, b, c, d);
    push_cyc = cyc;
    if (expect_res) sb_push(op, a, b, c, d);
    @(negedge clk);
    sif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (sif.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, sif.busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_compute(input int c0, input int limit);
    int n;
    n = 0;
    while (n_compute == c0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("compute_seen", n_compute - c0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, sif.cmd_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, sif.busy}, 32'd0);
    check({tag, "_strobes"}, {29'd0, sif.compute, sif.res_valid, sif.err}, 32'd0);
    check({tag, "_AB"}, {sif.A, sif.B}, 32'd0);
    check({tag, "_CD"}, {sif.C, sif.D}, 32'd0);
    check({tag, "_opcodes"}, {16'd0, sif.opcode, sif.res_opcode}, 32'd0);
    check({tag, "_res"}, {sif.res_data, sif.res_im}, 32'd0);
`ifdef MP_SEQ_ERRCNT_EN
    check({tag, "_err_count"}, {24'd0, sif.err_count}, 32'd0);
`endif
  endtask

  vec_t tbl[8];
  int   c0, e0, r0, exp_errcnt;

  initial begin
    tbl[0] = '{8'd0,  16'd2,  16'd2,  16'd0,  16'd0,  1'b0};
    tbl[1] = '{8'd7,  16'd3,  16'd5,  16'd7,  16'd9,  1'b0};
    tbl[2] = '{8'd1,  16'd10, 16'd3,  16'd0,  16'd0,  1'b0};
    tbl[3] = '{8'd12, 16'd4,  16'd4,  16'd4,  16'd4,  1'b1};
    tbl[4] = '{8'd1,  16'd7,  16'd9,  16'd0,  16'd0,  1'b0};
    tbl[5] = '{8'd9,  16'h1234, 16'h00FF, 16'h0F0F, 16'h0001, 1'b0};
    tbl[6] = '{8'd10, 16'd1,  16'd1,  16'd1,  16'd1,  1'b1};
    tbl[7] = '{8'd8,  16'hFFFF, 16'h0002, 16'h8000, 16'h0003, 1'b0};
    exp_errcnt = 0;

    reset = 1'b1;
    sif.cmd_valid = 1'b0;
    sif.cmd_opcode = '0;
    sif.cmd_a = '0;
    sif.cmd_b = '0;
    sif.cmd_c = '0;
    sif.cmd_d = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      c0 = n_compute;
      e0 = n_err;
      push_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, !tbl[i].exp_err);
      wait_idle(300, "vec_idle_timeout");
      check("vec_compute_count", n_compute - c0, tbl[i].exp_err ? 0 : 1);
      check("vec_err_count", n_err - e0, tbl[i].exp_err ? 1 : 0);
      if (!tbl[i].exp_err) check("push_to_compute", comp_cyc - push_cyc, 2);
      if (tbl[i].exp_err) exp_errcnt++;
`ifdef MP_SEQ_ERRCNT_EN
      check("err_count_out", {24'd0, sif.err_count}, exp_errcnt);
`endif
    end

    // Fill the FIFO while a long op sits in WAIT; the fifth push must be refused.
    c0 = n_compute;
    push_cmd(8'd7, 16'd1, 16'd1, 16'd0, 16'd0, 1'b1);
    wait_compute(c0, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fill_cmd_ready", {31'd0, sif.cmd_ready}, (i < 4) ? 32'd1 : 32'd0);
      case (i)
        0: begin drive(8'd1, 16'd10, 16'd3, 16'd0, 16'd0); sb_push(8'd1, 16'd10, 16'd3, 16'd0, 16'd0); end
        1: begin drive(8'd2, 16'd5, 16'd5, 16'd0, 16'd0);  sb_push(8'd2, 16'd5, 16'd5, 16'd0, 16'd0); end
        2: begin drive(8'd3, 16'd8, 16'd2, 16'd0, 16'd0);  sb_push(8'd3, 16'd8, 16'd2, 16'd0, 16'd0); end
        3: begin drive(8'd4, 16'd10, 16'd8, 16'd6, 16'd4); sb_push(8'd4, 16'd10, 16'd8, 16'd6, 16'd4); end
        default: drive(8'd5, 16'd99, 16'd1, 16'd0, 16'd0);
      endcase
    end
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    check("full_cmd_ready_low", {31'd0, sif.cmd_ready}, 32'd0);
    wait_idle(900, "full_drain_timeout");
    check("full_compute_count", n_compute - c0, 5);
    check("full_scoreboard_empty", sbq.size(), 0);

    // Second push lands in the cycle IDLE pops the first.
    @(negedge clk);
    drive(8'd0, 16'd1, 16'd2, 16'd0, 16'd0);
    sb_push(8'd0, 16'd1, 16'd2, 16'd0, 16'd0);
    @(negedge clk);
    drive(8'd2, 16'd3, 16'd4, 16'd0, 16'd0);
    sb_push(8'd2, 16'd3, 16'd4, 16'd0, 16'd0);
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    check("pushpop_count", {27'd0, dut.count_q}, 32'd1);
    check("pushpop_cmd_ready", {31'd0, sif.cmd_ready}, 32'd1);
    wait_idle(100, "pushpop_idle_timeout");
    check("pushpop_scoreboard_empty", sbq.size(), 0);

    // Reset three cycles after compute abandons the calculation.
    c0 = n_compute;
    push_cmd(8'd0, 16'd2, 16'd2, 16'd0, 16'd0, 1'b0);
    wait_compute(c0, 20);
    r0 = n_res;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("midwait");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midwait_no_res_valid", n_res - r0, 0);
    check("midwait_busy", {31'd0, sif.busy}, 32'd0);
    check("final_scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
